// File: rtl/param_shift_bank_pkg.sv
// Shared encodings for the parametrised shift bank.
// Mode codes, FSM states and a burst-mode helper.
package param_shift_bank_pkg;

  localparam logic [2:0] MODE_HOLD  = 3'b000;
  localparam logic [2:0] MODE_SHL   = 3'b001;
  localparam logic [2:0] MODE_SHR   = 3'b010;
  localparam logic [2:0] MODE_ROL   = 3'b011;
  localparam logic [2:0] MODE_ROR   = 3'b100;
  localparam logic [2:0] MODE_LOAD  = 3'b101;
  localparam logic [2:0] MODE_CLEAR = 3'b110;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  function automatic logic is_burst(input logic [2:0] m);
    return (m == MODE_SHL) || (m == MODE_SHR) ||
           (m == MODE_ROL) || (m == MODE_ROR);
  endfunction

endpackage

// File: rtl/param_shift_bank_step.sv
// Combinational next-slot computation for one bank step.
// Slot k lives at bits [k*WIDTH +: WIDTH]; slot 0 is the LSB end.
module shift_step_unit
  import param_shift_bank_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int DEPTH = 8
) (
  input  logic [2:0]             op,
  input  logic [WIDTH*DEPTH-1:0] slots,
  input  logic [WIDTH-1:0]       din,
  input  logic [WIDTH*DEPTH-1:0] load_data,
  output logic [WIDTH*DEPTH-1:0] nxt
);

  localparam int TOP = WIDTH*DEPTH;
  localparam int LOW = WIDTH*(DEPTH-1);

  always_comb begin
    nxt = slots;
    case (op)
      MODE_SHL:   nxt = {slots[LOW-1:0], din};
      MODE_SHR:   nxt = {din, slots[TOP-1:WIDTH]};
      MODE_ROL:   nxt = {slots[LOW-1:0], slots[TOP-1 -: WIDTH]};
      MODE_ROR:   nxt = {slots[WIDTH-1:0], slots[TOP-1:WIDTH]};
      MODE_LOAD:  nxt = load_data;
      MODE_CLEAR: nxt = '0;
      default:    nxt = slots;
    endcase
  end

endmodule

// File: rtl/param_shift_bank.sv
// DEPTH x WIDTH register bank with mode-driven steps
// and a counted burst engine with Busy/Done handshake.
module param_shift_bank
  import param_shift_bank_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int DEPTH = 8,
  parameter int CNT_W = 8
) (
  input  logic                   Clk,
  input  logic                   Rst_n,
  input  logic                   En,
  input  logic [2:0]             Mode,
  input  logic [WIDTH-1:0]       Din,
  input  logic [WIDTH*DEPTH-1:0] Load_data,
  input  logic                   Start,
  input  logic [CNT_W-1:0]       Count,
  output logic [WIDTH*DEPTH-1:0] Dout,
  output logic [WIDTH-1:0]       Sout_l,
  output logic [WIDTH-1:0]       Sout_r,
  output logic                   Busy,
  output logic                   Done
);

  state_e                 state, state_n;
  logic [CNT_W-1:0]       remaining, rem_n;
  logic [2:0]             lat_mode, lat_n;
  logic                   done_n;
  logic [2:0]             op;
  logic [WIDTH*DEPTH-1:0] slots, slots_n;

  shift_step_unit #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_step (
    .op        (op),
    .slots     (slots),
    .din       (Din),
    .load_data (Load_data),
    .nxt       (slots_n)
  );

  always_comb begin
    state_n = state;
    rem_n   = remaining;
    lat_n   = lat_mode;
    done_n  = 1'b0;
    op      = MODE_HOLD;
    if (En) begin
      unique case (state)
        ST_IDLE: begin
          if (Start && is_burst(Mode)) begin
            if (Count != '0) begin
              state_n = ST_RUN;
              rem_n   = Count;
              lat_n   = Mode;
            end else begin
              done_n = 1'b1;
            end
          end else begin
            op = Mode;
          end
        end
        ST_RUN: begin
          // CLEAR is the only input honoured mid-burst: abort silently
          if (Mode == MODE_CLEAR) begin
            op      = MODE_CLEAR;
            state_n = ST_IDLE;
            rem_n   = '0;
          end else begin
            op    = lat_mode;
            rem_n = remaining - 1'b1;
            if (remaining == CNT_W'(1)) begin
              state_n = ST_IDLE;
              done_n  = 1'b1;
            end
          end
        end
        default: state_n = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state     <= ST_IDLE;
      remaining <= '0;
      lat_mode  <= MODE_HOLD;
      slots     <= '0;
      Done      <= 1'b0;
    end else begin
      state     <= state_n;
      remaining <= rem_n;
      lat_mode  <= lat_n;
      slots     <= slots_n;
      Done      <= done_n;
    end
  end

  assign Dout   = slots;
  assign Sout_l = slots[WIDTH*DEPTH-1 -: WIDTH];
  assign Sout_r = slots[WIDTH-1:0];
  assign Busy   = (state == ST_RUN);

endmodule

// File: doc/param_shift_bank.md
Name: param_shift_bank

Overview:
- Parametrised successor of the 8-digit, 4-bit display shift register.
- A DEPTH-slot by WIDTH-bit register bank with an explicit mode input instead of in-band data codes.
- Modes: hold, shift left/right with serial fill, rotate left/right, parallel load, and synchronous clear.
- A burst engine performs Count steps from a single Start, with Busy/Done handshake; it feeds the 7-segment scan driver and serial links.

Parameters:
- WIDTH, 4, bits per slot (one hex digit).
- DEPTH, 8, number of slots (must be >= 2).
- CNT_W, 8, width of the burst step counter.

Ports:
- Clk  input  1  rising-edge clock.
- Rst_n  input  1  asynchronous active-low reset.
- En  input  1  clock enable; low freezes all state except Done clearing.
- Mode  input  3  000 HOLD, 001 SHL, 010 SHR, 011 ROL, 100 ROR, 101 LOAD, 110 CLEAR, 111 reserved (treated as HOLD).
- Din  input  WIDTH  serial fill value for SHL/SHR.
- Load_data  input  WIDTH*DEPTH  parallel load value; slot k is bits [k*WIDTH +: WIDTH].
- Start  input  1  begin a burst of Count steps of Mode.
- Count  input  CNT_W  burst length in steps.
- Dout  output  WIDTH*DEPTH  all slots, same packing as Load_data.
- Sout_l  output  WIDTH  slot DEPTH-1 (combinational from register).
- Sout_r  output  WIDTH  slot 0 (combinational from register).
- Busy  output  1  burst in progress.
- Done  output  1  one-cycle pulse when a burst completes.

Behaviour:
- Reset (Rst_n low, async): all slots 0, state IDLE, remaining 0, latched mode HOLD, Busy 0, Done 0. Takes effect immediately, including mid-burst; no Done is produced.
- Step definitions:
  - SHL: slot k <= slot k-1 for k >= 1; slot0 <= Din.
  - SHR: slot k <= slot k+1 for k <= DEPTH-2; slot DEPTH-1 <= Din.
  - ROL: slot0 <= old slot DEPTH-1, otherwise as SHL.
  - ROR: slot DEPTH-1 <= old slot0, otherwise as SHR.
  - LOAD: all slots <= Load_data.
  - CLEAR: all slots <= 0.
  - HOLD and 111: no change.
- Done defaults to 0 every cycle unless set as below; En does not gate Done clearing.
- State IDLE (Busy=0), on each edge with En=1:
  - Start=1, Mode in {SHL,SHR,ROL,ROR}, Count!=0: latch Mode and Count into remaining, go to RUN. Dout does not change on this edge.
  - Start=1, Mode in {SHL,SHR,ROL,ROR}, Count=0: stay in IDLE, no data change, Done=1 for the next cycle.
  - Start=1 with any other Mode: Start is ignored and Mode executes as a single-cycle command.
  - Start=0: Mode executes once on this edge (single-cycle command, latency 1).
- State RUN (Busy=1), on each edge with En=1:
  - Perform one step of the latched mode, sampling Din at that edge; remaining decrements.
  - If remaining==1 before the edge: go to IDLE and Done=1 for the next cycle.
  - Result: Count=N gives exactly N steps on the N edges after the accepting edge. Busy is high from the accepting edge through the last step; Done rises with Busy's fall.
- En=0 in RUN: the burst pauses, with no step and no decrement. En=0 in IDLE: commands and Start are ignored.
- Priority in RUN with En=1:
  - Mode=CLEAR aborts: slots clear, go to IDLE, no Done.
  - All other Mode values, Start and Count are ignored.
- Load_data is sampled only on LOAD edges. Sout_l and Sout_r have zero latency from the register.

Decomposition:
- Shared package: mode encodings (MODE_HOLD..MODE_CLEAR) and FSM state constants (ST_IDLE, ST_RUN).
- One sub-module, shift_step_unit: combinational next-slot-array computation from {op, slots, Din, Load_data}. The top holds the registers, FSM and counter.

Test Plan (WIDTH=4, DEPTH=8):
- Reset then LOAD 0x76543210 -> Dout=0x76543210, Sout_l=7, Sout_r=0, Busy=0. Assert Rst_n low mid-burst -> Dout=0 immediately, Busy=0, no Done.
- Single SHL with Din=0xA from 0x76543210 -> 0x6543210A. Single SHR with Din=0xB from 0x76543210 -> 0xB7654321.
- Start ROL with Count=3 on 0x76543210 -> Busy high for 3 cycles after acceptance, Dout=0x43210765, Done high exactly one cycle, Busy low.
- Start ROR with Count=8 -> Dout returns to the original value, Done pulses once. Toggle En low for 2 cycles mid-burst -> completion is delayed by 2 cycles with the same final Dout.
- Start SHL with Count=0 -> Dout unchanged, Busy stays 0, Done pulses the next cycle. Start with Mode=LOAD -> behaves as a single load with no Busy.
- During a burst (Count=5), Mode=CLEAR with En=1 -> Dout=0 next cycle, Busy=0, no Done. Start issued mid-burst with another mode -> ignored, original burst completes.
